// File: rtl/msk_rnd_pkg.sv
// Shared definitions for the masked-gadget randomness source: default xorshift128
// seed, FSM state encoding and the gadget randomness width helper.
package msk_rnd_pkg;

  localparam logic [31:0] DEF_X = 32'd123456789;
  localparam logic [31:0] DEF_Y = 32'd362436069;
  localparam logic [31:0] DEF_Z = 32'd521288629;
  localparam logic [31:0] DEF_W = 32'd88675123;
  localparam logic [127:0] DEF_SEED = {DEF_X, DEF_Y, DEF_Z, DEF_W};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } rnd_state_e;

  // Random bits consumed by ngadgets HPC2 AND gadgets of share count d.
  function automatic int rnd_bits(input int d, input int ngadgets);
    return ngadgets * d * (d - 1) / 2;
  endfunction

endpackage

// File: rtl/msk_xorshift128_step.sv
// One combinational xorshift128 step; state packed {x,y,z,w} with x in [127:96].
module msk_xorshift128_step (
  input  logic [127:0] state_in,
  output logic [127:0] state_out,
  output logic [31:0]  w_out
);

  logic [31:0] x, y, z, w, t, w_new;

  assign x = state_in[127:96];
  assign y = state_in[95:64];
  assign z = state_in[63:32];
  assign w = state_in[31:0];

  assign t     = x ^ (x << 11);
  assign w_new = w ^ (w >> 19) ^ t ^ (t >> 8);

  assign state_out = {y, z, w, w_new};
  assign w_out     = w_new;

endmodule

// File: rtl/msk_rnd_source.sv
// Seeded xorshift128 randomness source with valid/ready delivery to HPC2 gadgets.
// Optional transfer counter and reseed_req advisory under MSK_RND_RESEED_CNT_EN.
module msk_rnd_source
  import msk_rnd_pkg::*;
#(
  parameter int d            = 2,
  parameter int NGADGETS     = 4,
  parameter int RND_BITS     = rnd_bits(d, NGADGETS),
  parameter int UNROLL       = 1,
  parameter int WARMUP       = 8,
  parameter int RESEED_LIMIT = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [127:0]        seed,
  input  logic                seed_valid,
  output logic                seed_ready,
  output logic [RND_BITS-1:0] rnd,
  output logic                rnd_valid,
  input  logic                rnd_ready,
  output logic                busy,
`ifdef MSK_RND_RESEED_CNT_EN
  output logic                reseed_req,
`endif
  output rnd_state_e          dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are
  // both high; valid never depends on ready, and rnd/rnd_valid are registers.
  if (RND_BITS > 32 * UNROLL || RND_BITS < 1) begin : g_width_err
    $error("msk_rnd_source: RND_BITS must be in 1..32*UNROLL");
  end

  localparam int WCW = $clog2(WARMUP + 2);
  localparam logic [WCW-1:0] WARM_INIT = WCW'(WARMUP);
  localparam logic [WCW-1:0] WARM_LAST = WCW'(1);

  rnd_state_e          state_q;
  logic [127:0]        st_q;
  logic [WCW-1:0]      warm_q;
  logic [127:0]        step_src;
  logic [127:0]        chain [UNROLL+1];
  logic [31:0]         w_arr [UNROLL];
  logic [RND_BITS-1:0] rnd_next;
  logic                seed_acc;
  logic                xfer;
  logic                adv;

  assign seed_acc = seed_valid && seed_ready;
  assign xfer     = rnd_valid && rnd_ready;
  assign adv      = (state_q == ST_SEED) || (state_q == ST_WARMUP) || xfer;

  // An all-zero seed would lock the generator at zero, so substitute the defaults.
  assign step_src = (state_q == ST_SEED && st_q == '0) ? DEF_SEED : st_q;
  assign chain[0] = step_src;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    localparam int LO = 32 * i;
    msk_xorshift128_step u_step (
      .state_in  (chain[i]),
      .state_out (chain[i+1]),
      .w_out     (w_arr[i])
    );
    if (LO < RND_BITS) begin : g_tap
      localparam int NB = (RND_BITS - LO > 32) ? 32 : RND_BITS - LO;
      assign rnd_next[LO +: NB] = w_arr[i][NB-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      st_q       <= '0;
      warm_q     <= '0;
      rnd        <= '0;
      rnd_valid  <= 1'b0;
      seed_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (adv) begin
        st_q <= chain[UNROLL];
        rnd  <= rnd_next;
      end
      unique case (state_q)
        ST_IDLE: seed_ready <= 1'b1;
        ST_SEED: begin
          if (WARMUP == 0) begin
            state_q    <= ST_RUN;
            busy       <= 1'b0;
            rnd_valid  <= 1'b1;
            seed_ready <= 1'b1;
          end else begin
            state_q <= ST_WARMUP;
            warm_q  <= WARM_INIT;
          end
        end
        ST_WARMUP: begin
          warm_q <= warm_q - WARM_LAST;
          if (warm_q == WARM_LAST) begin
            state_q    <= ST_RUN;
            busy       <= 1'b0;
            rnd_valid  <= 1'b1;
            seed_ready <= 1'b1;
          end
        end
        ST_RUN: ;
        default: state_q <= ST_IDLE;
      endcase
      // Seed acceptance overrides any same-cycle advance of the generator state.
      if (seed_acc) begin
        st_q       <= seed;
        state_q    <= ST_SEED;
        rnd_valid  <= 1'b0;
        seed_ready <= 1'b0;
        busy       <= 1'b1;
      end
    end
  end

  assign dbg_state = state_q;

`ifdef MSK_RND_RESEED_CNT_EN
  logic [31:0] xfer_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else if (seed_acc) begin
      xfer_cnt_q <= '0;
    end else if (xfer && xfer_cnt_q != '1) begin
      xfer_cnt_q <= xfer_cnt_q + 32'd1;
    end
  end

  assign reseed_req = (xfer_cnt_q >= 32'(RESEED_LIMIT));
`endif

endmodule
